// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM scheduler: sprite geometry,
// frame-select width and the per-sprite descriptor held in the shadow registers.
package sprite_pkg;

  localparam int SPR_W = 16;
  localparam int SPR_H = 16;
  localparam int FRM_W = 2;
  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  typedef logic [9:0] spr_pos_t;

  typedef struct packed {
    spr_pos_t         x;
    spr_pos_t         y;
    logic [FRM_W-1:0] frame;
    logic             en;
  } spr_desc_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Per-sprite coverage test: does the current pixel fall inside this sprite's box,
// and where inside the sprite bitmap does it land.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  spr_desc_t                desc,
  output logic                     hit,
  output logic [$clog2(SPR_W)-1:0] dx_w,
  output logic [$clog2(SPR_H)-1:0] dy_w
);

  logic [9:0] dx, dy;

  assign dx = DrawX - desc.x;
  assign dy = DrawY - desc.y;

  // The >= terms stop a sprite near x/y=1023 from wrapping onto column/row 0;
  // anything past the right/bottom edge simply never gets drawn.
  assign hit = desc.en
            && (DrawX >= desc.x) && (DrawY >= desc.y)
            && (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));

  assign dx_w = dx[$clog2(SPR_W)-1:0];
  assign dy_w = dy[$clog2(SPR_H)-1:0];

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Shares one synchronous sprite ROM among NUM_SPR objects: fixed-priority winner
// selection, 3-cycle aligned palette output and per-frame overlap flags.
module sprite_rom_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPR  = 4,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int FRM_W    = 2,
  parameter int ADDR_W   = 10,
  parameter int V_ACTIVE = 480
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic                     blank,
  input  logic [NUM_SPR*10-1:0]    spr_x,
  input  logic [NUM_SPR*10-1:0]    spr_y,
  input  logic [NUM_SPR*FRM_W-1:0] spr_frame,
  input  logic [NUM_SPR-1:0]       spr_en,
  output logic [ADDR_W-1:0]        rom_address,
  input  logic [3:0]               rom_q,
  output logic                     pix_valid,
  output logic [3:0]               pix_index,
  output logic [NUM_SPR-1:0]       collision,
  output logic                     frame_done
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);
  localparam logic [9:0] V_END = 10'(V_ACTIVE);

  spr_desc_t [NUM_SPR-1:0]         shd_q, shd_d;
  logic [NUM_SPR-1:0]              hit;
  logic [NUM_SPR-1:0][XB-1:0]      dx_w;
  logic [NUM_SPR-1:0][YB-1:0]      dy_w;

  logic [ADDR_W-1:0]               rom_addr_q, rom_addr_d;
  logic [1:0]                      hit_pipe_q, blk_pipe_q;
  logic                            pix_valid_q, pix_valid_d;
  logic [3:0]                      pix_index_q;
  logic [NUM_SPR-1:0]              acc_q, acc_d, coll_q;
  logic                            frame_done_q;
  logic                            hit_any, multi_hit, frame_end;

  genvar g;
  generate
    for (g = 0; g < NUM_SPR; g++) begin : g_spr
      assign shd_d[g].x     = spr_x[10*g +: 10];
      assign shd_d[g].y     = spr_y[10*g +: 10];
      assign shd_d[g].frame = spr_frame[FRM_W*g +: FRM_W];
      assign shd_d[g].en    = spr_en[g];

      sprite_hit_test #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
      ) u_hit (
        .DrawX (DrawX),
        .DrawY (DrawY),
        .desc  (shd_q[g]),
        .hit   (hit[g]),
        .dx_w  (dx_w[g]),
        .dy_w  (dy_w[g])
      );
    end
  endgenerate

  assign hit_any   = |hit;
  assign multi_hit = |(hit & (hit - 1'b1));
  assign frame_end = (DrawY == V_END) && (DrawX == 10'd0);

  // Walk downward so the lowest-index hitter is the last to write; no hit keeps
  // the old address so the ROM address bus stays quiet between sprites.
  always_comb begin
    rom_addr_d = rom_addr_q;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit[i]) rom_addr_d = {shd_q[i].frame, dy_w[i], dx_w[i]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (blank && multi_hit) acc_d = acc_q | hit;
  end

  // Transparency is decided only on the winner's data; lower sprites never show through.
  assign pix_valid_d = hit_pipe_q[1] & blk_pipe_q[1] & (rom_q != TRANSPARENT_IDX);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      shd_q        <= '0;
      rom_addr_q   <= '0;
      hit_pipe_q   <= '0;
      blk_pipe_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_index_q  <= '0;
      acc_q        <= '0;
      coll_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      hit_pipe_q   <= {hit_pipe_q[0], hit_any};
      blk_pipe_q   <= {blk_pipe_q[0], blank};
      pix_valid_q  <= pix_valid_d;
      pix_index_q  <= pix_valid_d ? rom_q : TRANSPARENT_IDX;
      frame_done_q <= frame_end;
      if (frame_end) begin
        shd_q  <= shd_d;
        coll_q <= acc_d;
        acc_q  <= '0;
      end else begin
        acc_q  <= acc_d;
      end
    end
  end

  assign rom_address = rom_addr_q;
  assign pix_valid   = pix_valid_q;
  assign pix_index   = pix_index_q;
  assign collision   = coll_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Directed bench for sprite_rom_scheduler; the ROM is a 1-cycle sync RAM whose
// word content equals address[3:0].
module tb_sprite_rom_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [39:0] spr_x, spr_y;
  logic [7:0]  spr_frame;
  logic [3:0]  spr_en;
  logic [9:0]  rom_address;
  logic [3:0]  rom_q;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic [3:0]  collision;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  sprite_rom_scheduler dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_frame   (spr_frame),
    .spr_en      (spr_en),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
    .collision   (collision),
    .frame_done  (frame_done)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom_address[3:0];

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    logic [9:0] addr;
    logic       v;
    logic [3:0] idx;
  } vec_t;

  vec_t vt[9];

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [1:0] f, input logic en);
    spr_x[10*i +: 10]  = x;
    spr_y[10*i +: 10]  = y;
    spr_frame[2*i +: 2] = f;
    spr_en[i]          = en;
  endtask

  task automatic pix(input string nm, input logic [9:0] x, input logic [9:0] y, input logic b,
                     input logic [9:0] ea, input logic ev, input logic [3:0] ei);
    DrawX = x; DrawY = y; blank = b;
    tick;
    chk({nm, ".addr"}, 32'(rom_address), 32'(ea));
    tick;
    tick;
    chk({nm, ".valid"}, 32'(pix_valid), 32'(ev));
    chk({nm, ".index"}, 32'(pix_index), 32'(ei));
  endtask

  task automatic frame_end(input string nm, input logic [3:0] ecoll);
    DrawX = 10'd0; DrawY = 10'd480; blank = 1'b0;
    tick;
    chk({nm, ".fdone_hi"}, 32'(frame_done), 32'd1);
    chk({nm, ".coll"}, 32'(collision), 32'(ecoll));
    DrawX = 10'd1; DrawY = 10'd481;
    tick;
    chk({nm, ".fdone_lo"}, 32'(frame_done), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".addr"},  32'(rom_address), 32'd0);
    chk({nm, ".valid"}, 32'(pix_valid),   32'd0);
    chk({nm, ".index"}, 32'(pix_index),   32'd0);
    chk({nm, ".coll"},  32'(collision),   32'd0);
    chk({nm, ".fdone"}, 32'(frame_done),  32'd0);
  endtask

  initial begin
    // Config A: s0 (100,50) f0, s1 (1020,300) f3, s2 off, s3 (400,400) f2
    vt[0] = '{x:103,  y:52,  b:1, addr:10'h023, v:1, idx:4'h3};
    vt[1] = '{x:2,    y:300, b:1, addr:10'h023, v:0, idx:4'h0};
    vt[2] = '{x:1023, y:305, b:1, addr:10'h353, v:1, idx:4'h3};
    vt[3] = '{x:100,  y:50,  b:1, addr:10'h000, v:0, idx:4'h0};
    vt[4] = '{x:115,  y:65,  b:1, addr:10'h0FF, v:1, idx:4'hF};
    vt[5] = '{x:116,  y:50,  b:1, addr:10'h0FF, v:0, idx:4'h0};
    vt[6] = '{x:110,  y:60,  b:0, addr:10'h0AA, v:0, idx:4'h0};
    vt[7] = '{x:405,  y:409, b:1, addr:10'h295, v:1, idx:4'h5};
    vt[8] = '{x:99,   y:50,  b:1, addr:10'h295, v:0, idx:4'h0};

    reset_n = 1'b0;
    DrawX = '0; DrawY = '0; blank = 1'b0;
    spr_x = '0; spr_y = '0; spr_frame = '0; spr_en = '0;
    set_spr(0, 10'd100,  10'd50,  2'd0, 1'b1);
    set_spr(1, 10'd1020, 10'd300, 2'd3, 1'b1);
    set_spr(2, 10'd0,    10'd0,   2'd0, 1'b0);
    set_spr(3, 10'd400,  10'd400, 2'd2, 1'b1);
    tick;
    tick;
    chk_zero("reset");
    reset_n = 1'b1;
    tick;

    // Shadows still empty: nothing may be drawn before the first frame end
    pix("preload", 10'd103, 10'd52, 1'b1, 10'h000, 1'b0, 4'h0);
    frame_end("fe0", 4'b0000);

    for (int i = 0; i < 9; i++)
      pix($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].b, vt[i].addr, vt[i].v, vt[i].idx);

    // Mid-frame move is invisible until the next frame end
    set_spr(0, 10'd300, 10'd50, 2'd0, 1'b1);
    pix("tear_old", 10'd103, 10'd52, 1'b1, 10'h023, 1'b1, 4'h3);
    frame_end("fe1", 4'b0000);
    pix("tear_gone", 10'd103, 10'd52, 1'b1, 10'h023, 1'b0, 4'h0);
    pix("tear_new",  10'd305, 10'd53, 1'b1, 10'h035, 1'b1, 4'h5);

    // Config B: s0 and s1 overlap around (200,200)
    set_spr(0, 10'd195, 10'd190, 2'd1, 1'b1);
    set_spr(1, 10'd198, 10'd196, 2'd2, 1'b1);
    set_spr(3, 10'd400, 10'd400, 2'd2, 1'b0);
    frame_end("fe2", 4'b0000);
    pix("ovl_blank", 10'd200, 10'd200, 1'b0, 10'h1A5, 1'b0, 4'h0);
    frame_end("fe3", 4'b0000);
    pix("ovl_prio", 10'd200, 10'd200, 1'b1, 10'h1A5, 1'b1, 4'h5);
    pix("ovl_s1",   10'd212, 10'd205, 1'b1, 10'h29E, 1'b1, 4'hE);
    frame_end("fe4", 4'b0011);

    // Asynchronous reset mid-line, then nothing until shadows reload
    DrawX = 10'd200; DrawY = 10'd200; blank = 1'b1;
    tick;
    tick;
    tick;
    chk("pre_rst.valid", 32'(pix_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    tick;
    reset_n = 1'b1;
    pix("post_rst", 10'd200, 10'd200, 1'b1, 10'h000, 1'b0, 4'h0);
    frame_end("fe5", 4'b0000);
    pix("reloaded", 10'd200, 10'd200, 1'b1, 10'h1A5, 1'b1, 4'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
